// File: rtl/lsu_dmem.sv
// lsu_dmem: byte-masked data memory with RISC-V load/store front end, 1-cycle registered
// response, misalignment detection and post-reset self-clear.
module lsu_dmem #(
    parameter int ADDR_W = 11,
    parameter bit CLR_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int IW = ADDR_W - 2;
    localparam logic [IW-1:0] LAST = '1;

    typedef enum logic [1:0] {INIT, CLEAR, READY} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  cnt_q, cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;

    logic [31:0]    mem [DEPTH];
    logic [IW-1:0]  word_idx, mem_idx;
    logic [1:0]     lane;
    logic           accept, err, clr, mem_we;
    logic [31:0]    rword, sh, load_data, wd, mem_wd;
    logic [3:0]     be, mem_be;

    always_comb begin
        word_idx    = i_req_addr[ADDR_W-1:2];
        lane        = i_req_addr[1:0];
        clr         = state_q == CLEAR;
        accept      = i_req_valid && state_q == READY;
        err         = i_req_size == 2'd3 || (i_req_size == 2'd1 && lane[0]) ||
                      (i_req_size == 2'd2 && lane != 2'd0);
        state_d     = state_q == INIT ? (CLR_EN ? CLEAR : READY) :
                      (clr && cnt_q == LAST) ? READY : state_q;
        cnt_d       = clr ? cnt_q + 1'b1 : cnt_q;
        rword       = mem[word_idx];
        sh          = rword >> {lane, 3'b000};
        load_data   = i_req_size == 2'd0 ? {{24{sh[7] & ~i_req_unsigned}}, sh[7:0]} :
                      i_req_size == 2'd1 ? {{16{sh[15] & ~i_req_unsigned}}, sh[15:0]} : rword;
        // Store data is replicated across lanes so the byte enables alone pick the target.
        be          = i_req_size == 2'd0 ? 4'b0001 << lane :
                      i_req_size == 2'd1 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd          = i_req_size == 2'd0 ? {4{i_req_wdata[7:0]}} :
                      i_req_size == 2'd1 ? {2{i_req_wdata[15:0]}} : i_req_wdata;
        mem_we      = clr || (accept && i_req_wr && !err);
        mem_idx     = clr ? cnt_q : word_idx;
        mem_be      = clr ? 4'b1111 : be;
        mem_wd      = clr ? 32'd0 : wd;
        rsp_valid_d = accept;
        rsp_err_d   = accept && err;
        rsp_rdata_d = (accept && !i_req_wr && !err) ? load_data : 32'd0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
    end

    assign o_req_ready = state_q == READY;
    assign o_busy      = state_q == CLEAR;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed table-driven bench for lsu_dmem plus reset/clear sequences.
module tb_lsu_dmem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [10:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_uns = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_dmem #(.ADDR_W(11), .CLR_EN(1'b1)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_size(req_size),
        .i_req_unsigned(req_uns), .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy)
    );

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [10:0] a, input logic [1:0] s, input logic u,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input string nm);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_size = v.size;
        req_uns = v.uns; req_wdata = v.wdata;
    endtask

    // Release reset on a falling edge and count busy samples until ready.
    task automatic release_and_clear(input string nm);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            else if (busy) n++;
        end
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_busy_cycles"}, n, 32'd512);
    endtask

    // Checks that the ready flag never rises while busy.
    always @(negedge clk) begin
        if (busy && req_ready) begin
            errors++;
            $display("FAIL ready_during_busy got=1 want=0");
        end
    end

    initial begin
        add(0, 11'h7FC, 2'd2, 0, 32'h0,        32'h00000000, 0, "lw_7fc_cleared");
        add(1, 11'h00C, 2'd2, 0, 32'hDEADBEEF, 32'h00000000, 0, "sw_00c");
        add(0, 11'h00C, 2'd2, 0, 32'h0,        32'hDEADBEEF, 0, "lw_00c_raw");
        add(1, 11'h00D, 2'd0, 0, 32'h12345678, 32'h00000000, 0, "sb_00d");
        add(0, 11'h00C, 2'd2, 0, 32'h0,        32'hDEAD78EF, 0, "lw_00c_after_sb");
        add(0, 11'h00D, 2'd0, 0, 32'h0,        32'h00000078, 0, "lb_00d");
        add(0, 11'h00F, 2'd0, 0, 32'h0,        32'hFFFFFFDE, 0, "lb_00f");
        add(0, 11'h00F, 2'd0, 1, 32'h0,        32'h000000DE, 0, "lbu_00f");
        add(1, 11'h012, 2'd1, 0, 32'h0000ABCD, 32'h00000000, 0, "sh_012");
        add(0, 11'h010, 2'd2, 0, 32'h0,        32'hABCD0000, 0, "lw_010");
        add(0, 11'h012, 2'd1, 0, 32'h0,        32'hFFFFABCD, 0, "lh_012");
        add(0, 11'h012, 2'd1, 1, 32'h0,        32'h0000ABCD, 0, "lhu_012");
        add(1, 11'h011, 2'd1, 0, 32'hFFFFFFFF, 32'h00000000, 1, "sh_011_misal");
        add(0, 11'h010, 2'd2, 0, 32'h0,        32'hABCD0000, 0, "lw_010_unchanged");
        add(0, 11'h016, 2'd2, 0, 32'h0,        32'h00000000, 1, "lw_016_misal");
        add(0, 11'h010, 2'd3, 0, 32'h0,        32'h00000000, 1, "size3_load");
        add(1, 11'h014, 2'd2, 0, 32'hCAFEF00D, 32'h00000000, 0, "sw_014");
        add(0, 11'h014, 2'd2, 0, 32'h0,        32'hCAFEF00D, 0, "lw_014_b2b");
        add(0, 11'h00E, 2'd1, 0, 32'h0,        32'hFFFFDEAD, 0, "lh_00e");
        add(0, 11'h00C, 2'd2, 1, 32'h0,        32'hDEAD78EF, 0, "lw_uns_ignored");
        add(1, 11'h010, 2'd0, 0, 32'h000000A5, 32'h00000000, 0, "sb_010");
        add(0, 11'h010, 2'd2, 0, 32'h0,        32'hABCD00A5, 0, "lw_010_after_sb");
        add(1, 11'h018, 2'd3, 0, 32'h00000001, 32'h00000000, 1, "size3_store");
        add(0, 11'h018, 2'd2, 0, 32'h0,        32'h00000000, 0, "lw_018_no_write");
        add(1, 11'h01B, 2'd0, 0, 32'h00000080, 32'h00000000, 0, "sb_01b");
        add(0, 11'h01A, 2'd1, 0, 32'h0,        32'hFFFF8000, 0, "lh_01a");

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        release_and_clear("clr1");

        // Back-to-back: vector i is driven while vector i-1's response is checked.
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i > 0) begin
                chk({vecs[i-1].name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
                chk({vecs[i-1].name, "_rdata"}, rsp_rdata, vecs[i-1].exp_rdata);
                chk({vecs[i-1].name, "_err"}, {31'd0, rsp_err}, {31'd0, vecs[i-1].exp_err});
            end
            if (i < vecs.size()) drive(vecs[i]);
            else req_valid = 1'b0;
            @(negedge clk);
        end
        chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_rdata", rsp_rdata, 32'd0);

        // In-flight response dropped by asynchronous reset.
        drive(vecs[2]);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        chk("inflight_valid_pre", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("inflight_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("inflight_ready_drop", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again partway through the clear.
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        chk("clr2_started", {31'd0, busy}, 32'd1);
        repeat (100) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midclr_busy_drop", {31'd0, busy}, 32'd0);
        chk("midclr_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        release_and_clear("clr3");

        drive(vecs[17]);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lw_014_after_clr_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lw_014_after_clr_rdata", rsp_rdata, 32'd0);
        chk("lw_014_after_clr_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        chk("final_idle_valid", {31'd0, rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
